memory_stage: RTL and testbench

//  Pipeline stage directly downstream of execute. Takes execute's registered outputs and the

---
 rtl/memory_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_memory_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// Pipeline stage that sits directly after execute. Each cycle it takes
// execute's registered outputs and the data-memory read word for addr[31:2].
// It does three things:
//   - aligns the loaded byte, double or word to bit 0 and extends it to 32 bits
//   - merges the two halves of a misaligned word or double load, using a
//     holding buffer that keeps the first half between the two accesses
//   - registers the result toward writeback
// The registered outputs also go back to execute as the wb_* forwarding and
// stall inputs. A partial (first-half) result never reaches writeback, because
// its target registers are forced to 0.
//
// Parameters
//   SIGN_EXT  1: sign-extend byte/double loads, 0: zero-extend
//   RST_PC    value pc_out takes at reset
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   clk_en, halt       state updates only when clk_en && !halt
//   bubble_in          this stage holds a bubble
//   opcode[4:0]        3-5 word, 6-8 double (16b), 9-11 byte memory ops
//   tgt_1, tgt_2       destination registers (0 = no write)
//   result_1/result_2  primary (ALU/link/crmov) and secondary (post-inc) results
//   addr               byte address of this access
//   is_load            instruction is a load
//   was_misaligned     this is the second access of a split load
//   tgts_cr            tgt_1 names a control register
//   exc_in             exception code from execute (0 = none)
//   pc_in              instruction PC
//   mem_rdata          read word from data memory
//   exc_in_wb/rfe_in_wb  exception or rfe in writeback: flush this stage
//   result_out_*, tgt_out_*, tgts_cr_out, bubble_out, exc_out, pc_out
//                      registered stage outputs toward writeback
//   split_pending      first half of a split load is in the holding buffer
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter bit          SIGN_EXT = 1'b0,
  parameter logic [31:0] RST_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        bubble_in,
  input  logic [4:0]  opcode,
  input  logic [4:0]  tgt_1,
  input  logic [4:0]  tgt_2,
  input  logic [31:0] result_1,
  input  logic [31:0] result_2,
  input  logic [31:0] addr,
  input  logic        is_load,
  input  logic        was_misaligned,
  input  logic        tgts_cr,
  input  logic [7:0]  exc_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  input  logic        exc_in_wb,
  input  logic        rfe_in_wb,
  output logic [31:0] result_out_1,
  output logic [31:0] result_out_2,
  output logic [4:0]  tgt_out_1,
  output logic [4:0]  tgt_out_2,
  output logic        tgts_cr_out,
  output logic        bubble_out,
  output logic [7:0]  exc_out,
  output logic [31:0] pc_out,
  output logic        split_pending
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HALF = 1'b1;

  // ---------------------------------------------------------------------------
  // Extension helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ext8(input logic [7:0] v);
    ext8 = SIGN_EXT ? {{24{v[7]}}, v} : {24'd0, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v);
    ext16 = SIGN_EXT ? {{16{v[15]}}, v} : {16'd0, v};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]  state;
  logic [31:0] hold;
  logic [1:0]  k_hold;
  logic        hold_dbl;   // held first half belongs to a double load

  // ---------------------------------------------------------------------------
  // Decode and load alignment
  // ---------------------------------------------------------------------------
  logic        is_word, is_double, is_byte;
  logic [1:0]  k;
  logic [31:0] shifted;
  logic [31:0] aligned_data;
  logic [31:0] plain_data;
  logic        first_half;
  logic        take_merge;
  logic [2:0]  merge_lanes;
  logic [31:0] merged_word;
  logic [31:0] merged_dbl;
  logic [31:0] data_val;
  logic        flush;
  logic        upd;

  assign is_word   = (opcode >= 5'd3) && (opcode <= 5'd5);
  assign is_double = (opcode >= 5'd6) && (opcode <= 5'd8);
  assign is_byte   = (opcode >= 5'd9) && (opcode <= 5'd11);
  assign k         = addr[1:0];

  // Move byte lane k down to bit 0 (little-endian lanes).
  assign shifted = mem_rdata >> {k, 3'b000};

  always_comb begin
    aligned_data = mem_rdata;
    if (is_double)    aligned_data = ext16(shifted[15:0]);
    else if (is_byte) aligned_data = ext8(shifted[7:0]);
  end

  assign plain_data = is_load ? aligned_data : result_1;

  // The first half of a load that crosses a word boundary. Accesses that
  // raise an exception never start a split.
  assign first_half = is_load && !bubble_in && !was_misaligned &&
                      (exc_in == 8'd0) &&
                      ((is_word && (k != 2'd0)) || (is_double && (k == 2'd3)));

  assign take_merge = (state == ST_HALF) && was_misaligned && !bubble_in;

  // The hold buffer already has the first (4-k_hold) bytes at the bottom, so
  // the second word supplies the upper k_hold bytes.
  assign merge_lanes = 3'd4 - {1'b0, k_hold};
  assign merged_word = hold | (mem_rdata << {merge_lanes, 3'b000});
  assign merged_dbl  = ext16({mem_rdata[7:0], hold[7:0]});

  assign data_val = take_merge ? (hold_dbl ? merged_dbl : merged_word)
                               : plain_data;

  assign flush = exc_in_wb || rfe_in_wb;
  assign upd   = clk_en && !halt;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  logic [0:0]  nxt_state;
  logic [31:0] nxt_hold;
  logic [1:0]  nxt_k_hold;
  logic        nxt_hold_dbl;
  logic [31:0] nxt_result_1;
  logic [4:0]  nxt_tgt_1;
  logic [4:0]  nxt_tgt_2;
  logic        nxt_bubble;
  logic [7:0]  nxt_exc;

  always_comb begin
    nxt_state    = state;
    nxt_hold     = hold;
    nxt_k_hold   = k_hold;
    nxt_hold_dbl = hold_dbl;
    nxt_result_1 = data_val;
    nxt_tgt_1    = tgt_1;
    nxt_tgt_2    = tgt_2;
    nxt_bubble   = 1'b0;
    nxt_exc      = 8'd0;

    if (flush) begin
      // Flush overrides everything else, including a pending split.
      nxt_state    = ST_IDLE;
      nxt_hold     = 32'd0;
      nxt_k_hold   = 2'd0;
      nxt_hold_dbl = 1'b0;
      nxt_tgt_1    = 5'd0;
      nxt_tgt_2    = 5'd0;
      nxt_bubble   = 1'b1;
    end else begin
      // A bubble while the first half is held is a stall: keep the buffer.
      // Any real instruction ends the split, either by merging (second half)
      // or by dropping the stale first half and being processed normally.
      if ((state == ST_HALF) && !bubble_in) begin
        nxt_state    = ST_IDLE;
        nxt_hold     = 32'd0;
        nxt_k_hold   = 2'd0;
        nxt_hold_dbl = 1'b0;
      end

      if (bubble_in) begin
        nxt_tgt_1  = 5'd0;
        nxt_tgt_2  = 5'd0;
        nxt_bubble = 1'b1;
      end else if (exc_in != 8'd0) begin
        nxt_tgt_1 = 5'd0;
        nxt_tgt_2 = 5'd0;
        nxt_exc   = exc_in;
      end else if (first_half) begin
        // Capture the first half; nothing is written back this cycle.
        nxt_state    = ST_HALF;
        nxt_hold     = shifted;
        nxt_k_hold   = k;
        nxt_hold_dbl = is_double;
        nxt_tgt_1    = 5'd0;
        nxt_tgt_2    = 5'd0;
        nxt_bubble   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage register toward writeback
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      hold         <= 32'd0;
      k_hold       <= 2'd0;
      hold_dbl     <= 1'b0;
      result_out_1 <= 32'd0;
      result_out_2 <= 32'd0;
      tgt_out_1    <= 5'd0;
      tgt_out_2    <= 5'd0;
      tgts_cr_out  <= 1'b0;
      bubble_out   <= 1'b1;
      exc_out      <= 8'd0;
      pc_out       <= RST_PC;
    end else if (upd) begin
      state        <= nxt_state;
      hold         <= nxt_hold;
      k_hold       <= nxt_k_hold;
      hold_dbl     <= nxt_hold_dbl;
      result_out_1 <= nxt_result_1;
      result_out_2 <= result_2;
      tgt_out_1    <= nxt_tgt_1;
      tgt_out_2    <= nxt_tgt_2;
      tgts_cr_out  <= tgts_cr;
      bubble_out   <= nxt_bubble;
      exc_out      <= nxt_exc;
      pc_out       <= pc_in;
    end
  end

  assign split_pending = (state == ST_HALF);

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// Directed bench for memory_stage. Two instances share every input: dut0 with
// SIGN_EXT=0 (RST_PC=0x1000) and dut1 with SIGN_EXT=1, so extension behaviour
// is compared side by side. Inputs change 1 ns after the rising edge and
// outputs are checked at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en, halt, bubble_in, is_load, was_misaligned, tgts_cr;
  logic        exc_in_wb, rfe_in_wb;
  logic [4:0]  opcode, tgt_1, tgt_2;
  logic [31:0] result_1, result_2, addr, pc_in, mem_rdata;
  logic [7:0]  exc_in;

  logic [31:0] r1_a, r2_a, pc_a, r1_b, r2_b, pc_b;
  logic [4:0]  t1_a, t2_a, t1_b, t2_b;
  logic        cr_a, bub_a, sp_a, cr_b, bub_b, sp_b;
  logic [7:0]  exc_a, exc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage #(.SIGN_EXT(1'b0), .RST_PC(32'h0000_1000)) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .bubble_in(bubble_in),
    .opcode(opcode), .tgt_1(tgt_1), .tgt_2(tgt_2), .result_1(result_1),
    .result_2(result_2), .addr(addr), .is_load(is_load),
    .was_misaligned(was_misaligned), .tgts_cr(tgts_cr), .exc_in(exc_in),
    .pc_in(pc_in), .mem_rdata(mem_rdata), .exc_in_wb(exc_in_wb),
    .rfe_in_wb(rfe_in_wb), .result_out_1(r1_a), .result_out_2(r2_a),
    .tgt_out_1(t1_a), .tgt_out_2(t2_a), .tgts_cr_out(cr_a), .bubble_out(bub_a),
    .exc_out(exc_a), .pc_out(pc_a), .split_pending(sp_a)
  );

  memory_stage #(.SIGN_EXT(1'b1), .RST_PC(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .bubble_in(bubble_in),
    .opcode(opcode), .tgt_1(tgt_1), .tgt_2(tgt_2), .result_1(result_1),
    .result_2(result_2), .addr(addr), .is_load(is_load),
    .was_misaligned(was_misaligned), .tgts_cr(tgts_cr), .exc_in(exc_in),
    .pc_in(pc_in), .mem_rdata(mem_rdata), .exc_in_wb(exc_in_wb),
    .rfe_in_wb(rfe_in_wb), .result_out_1(r1_b), .result_out_2(r2_b),
    .tgt_out_1(t1_b), .tgt_out_2(t2_b), .tgts_cr_out(cr_b), .bubble_out(bub_b),
    .exc_out(exc_b), .pc_out(pc_b), .split_pending(sp_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    clk_en = 1'b1; halt = 1'b0; bubble_in = 1'b0; is_load = 1'b0;
    was_misaligned = 1'b0; tgts_cr = 1'b0; exc_in_wb = 1'b0; rfe_in_wb = 1'b0;
    opcode = 5'd0; tgt_1 = 5'd0; tgt_2 = 5'd0; result_1 = 32'd0;
    result_2 = 32'd0; addr = 32'd0; pc_in = 32'd0; mem_rdata = 32'd0;
    exc_in = 8'd0;
  endtask

  task automatic ld(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rd,
                    input logic [4:0] t, input logic mis);
    clr();
    is_load = 1'b1; opcode = op; addr = a; mem_rdata = rd; tgt_1 = t;
    was_misaligned = mis;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #2;
    // Reset state
    chk("rst_bubble", {31'd0, bub_a}, 32'd1);
    chk("rst_tgt1", {27'd0, t1_a}, 32'd0);
    chk("rst_pc", pc_a, 32'h0000_1000);
    chk("rst_split", {31'd0, sp_a}, 32'd0);
    chk("rst_res1", r1_a, 32'd0);
    chk("rst_exc", {24'd0, exc_a}, 32'd0);
    step();
    rst = 1'b0;

    // Aligned lw
    ld(5'd3, 32'h100, 32'h1122_3344, 5'd5, 1'b0);
    pc_in = 32'h200;
    step();
    chk("lw_res", r1_a, 32'h1122_3344);
    chk("lw_tgt", {27'd0, t1_a}, 32'd5);
    chk("lw_bub", {31'd0, bub_a}, 32'd0);
    chk("lw_pc", pc_a, 32'h200);

    // lb lane 3, zero vs sign extension
    ld(5'd9, 32'h103, 32'h80AA_BBCC, 5'd6, 1'b0);
    step();
    chk("lb_zext", r1_a, 32'h0000_0080);
    chk("lb_sext", r1_b, 32'hFFFF_FF80);

    // Aligned double at lane 2
    ld(5'd6, 32'h102, 32'h80AA_1234, 5'd6, 1'b0);
    step();
    chk("ld_al_zext", r1_a, 32'h0000_80AA);
    chk("ld_al_sext", r1_b, 32'hFFFF_80AA);

    // Non-load passes result_1/result_2
    clr();
    result_1 = 32'hDEAD_BEEF; result_2 = 32'h1234_5678; tgt_1 = 5'd7; tgt_2 = 5'd8;
    tgts_cr = 1'b1;
    step();
    chk("alu_res1", r1_a, 32'hDEAD_BEEF);
    chk("alu_res2", r2_a, 32'h1234_5678);
    chk("alu_tgt2", {27'd0, t2_a}, 32'd8);
    chk("alu_cr", {31'd0, cr_a}, 32'd1);

    // Split lw at 0x101
    ld(5'd3, 32'h101, 32'h4433_2211, 5'd9, 1'b0);
    step();
    chk("slw1_bub", {31'd0, bub_a}, 32'd1);
    chk("slw1_tgt", {27'd0, t1_a}, 32'd0);
    chk("slw1_sp", {31'd0, sp_a}, 32'd1);
    ld(5'd3, 32'h104, 32'h8877_6655, 5'd9, 1'b1);
    step();
    chk("slw2_res", r1_a, 32'h5544_3322);
    chk("slw2_tgt", {27'd0, t1_a}, 32'd9);
    chk("slw2_bub", {31'd0, bub_a}, 32'd0);
    chk("slw2_sp", {31'd0, sp_a}, 32'd0);

    // Split ld at 0x103 with a one-cycle stall in between
    ld(5'd6, 32'h103, 32'hAA00_0000, 5'd10, 1'b0);
    step();
    chk("sld1_sp", {31'd0, sp_a}, 32'd1);
    clr();
    bubble_in = 1'b1;
    step();
    chk("stall_sp", {31'd0, sp_a}, 32'd1);
    chk("stall_bub", {31'd0, bub_a}, 32'd1);
    ld(5'd6, 32'h104, 32'h0000_00BB, 5'd10, 1'b1);
    step();
    chk("sld2_zext", r1_a, 32'h0000_BBAA);
    chk("sld2_sext", r1_b, 32'hFFFF_BBAA);
    chk("sld2_tgt", {27'd0, t1_a}, 32'd10);

    // halt and clk_en=0 freeze all state
    ld(5'd3, 32'h110, 32'h9999_9999, 5'd11, 1'b0);
    halt = 1'b1;
    step();
    chk("halt_res", r1_a, 32'h0000_BBAA);
    chk("halt_tgt", {27'd0, t1_a}, 32'd10);
    halt = 1'b0; clk_en = 1'b0;
    step();
    chk("cen_res", r1_a, 32'h0000_BBAA);

    // Exception from execute
    ld(5'd3, 32'h120, 32'h5555_5555, 5'd3, 1'b0);
    exc_in = 8'h05;
    step();
    chk("exc_code", {24'd0, exc_a}, 32'h05);
    chk("exc_tgt", {27'd0, t1_a}, 32'd0);
    chk("exc_bub", {31'd0, bub_a}, 32'd0);

    // Flush while HALF, then an aligned load
    ld(5'd3, 32'h102, 32'h1111_1111, 5'd12, 1'b0);
    step();
    chk("fl_sp_pre", {31'd0, sp_a}, 32'd1);
    ld(5'd3, 32'h104, 32'h2222_2222, 5'd12, 1'b1);
    exc_in_wb = 1'b1;
    step();
    chk("fl_bub", {31'd0, bub_a}, 32'd1);
    chk("fl_sp", {31'd0, sp_a}, 32'd0);
    chk("fl_tgt", {27'd0, t1_a}, 32'd0);
    ld(5'd3, 32'h108, 32'hCAFE_F00D, 5'd4, 1'b0);
    step();
    chk("post_fl_res", r1_a, 32'hCAFE_F00D);
    chk("post_fl_tgt", {27'd0, t1_a}, 32'd4);

    // Flush wins over a simultaneous first half
    ld(5'd3, 32'h101, 32'h3333_3333, 5'd13, 1'b0);
    rfe_in_wb = 1'b1;
    step();
    chk("flwin_sp", {31'd0, sp_a}, 32'd0);
    chk("flwin_bub", {31'd0, bub_a}, 32'd1);

    // HALF followed by an unrelated load: first half dropped, load processed
    ld(5'd3, 32'h103, 32'h4444_4444, 5'd14, 1'b0);
    step();
    ld(5'd3, 32'h10C, 32'h0102_0304, 5'd15, 1'b0);
    step();
    chk("drop_res", r1_a, 32'h0102_0304);
    chk("drop_tgt", {27'd0, t1_a}, 32'd15);
    chk("drop_sp", {31'd0, sp_a}, 32'd0);

    // Asynchronous reset in the middle of a HALF cycle
    ld(5'd3, 32'h101, 32'h4433_2211, 5'd9, 1'b0);
    pc_in = 32'h300;
    step();
    chk("arst_pre_sp", {31'd0, sp_a}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_bub", {31'd0, bub_a}, 32'd1);
    chk("arst_sp", {31'd0, sp_a}, 32'd0);
    chk("arst_pc", pc_a, 32'h0000_1000);
    chk("arst_res", r1_a, 32'd0);
    rst = 1'b0;
    // A second-half-looking access now must not merge with the discarded hold
    ld(5'd3, 32'h104, 32'h8877_6655, 5'd9, 1'b1);
    step();
    chk("arst_post_res", r1_a, 32'h8877_6655);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
